// File: rtl/dmem_responder.sv
// Data-memory responder for the RISC-V MEM stage: one load/store at a time on a
// word-organised RAM, committed after WAIT_STATES cycles, with a registered ready pulse.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] w_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int unsigned XLEN       = 32;
    localparam int unsigned LANES      = XLEN / 8;
    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned CNT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_INIT_I);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef struct packed {
        logic            rd;
        logic            wr;
        logic [2:0]      f3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;
    req_t             cur_c;
    logic [XLEN-1:0]  read_data_d;
    logic             ready_d, busy_d, err_d;
    logic             commit_c;
    logic             ram_we_c;

    logic [XLEN-1:0]  ram [DEPTH_WORDS];

    logic [XLEN-1:0]  off_c;
    logic [IDX_W-1:0] idx_c;
    logic             in_range_c, f3_ok_c, misalign_c, acc_err_c;
    logic [LANES-1:0] be_c;
    logic [XLEN-1:0]  wlane_c, rword_c, load_c;
    logic [7:0]       byte_c;
    logic [15:0]      half_c;

    // In IDLE the commit (WAIT_STATES==0) must see the incoming request; otherwise the latched one.
    assign cur_c = (state_q == S_IDLE) ? {mem_read, mem_write, funct3, address, w_data} : req_q;

    // Access decode: legality, lane enables, store lane data and extended load value.
    always_comb begin
        off_c      = cur_c.addr - BASE_ADDR;
        idx_c      = off_c[IDX_W+1:2];
        in_range_c = (cur_c.addr >= BASE_ADDR) && ((off_c >> 2) < XLEN'(DEPTH_WORDS));

        f3_ok_c = 1'b0;
        case (cur_c.f3)
            F3_B, F3_H, F3_W: f3_ok_c = 1'b1;
            F3_BU, F3_HU:     f3_ok_c = !cur_c.wr;
            default:          f3_ok_c = 1'b0;
        endcase

        misalign_c = ((cur_c.f3[1:0] == 2'b01) && off_c[0]) ||
                     ((cur_c.f3[1:0] == 2'b10) && (off_c[1:0] != 2'b00));
        acc_err_c  = (cur_c.rd && cur_c.wr) || !f3_ok_c || misalign_c || !in_range_c;

        be_c    = '0;
        wlane_c = cur_c.wdata;
        case (cur_c.f3[1:0])
            2'b00: begin
                be_c    = LANES'(1) << off_c[1:0];
                wlane_c = {4{cur_c.wdata[7:0]}};
            end
            2'b01: begin
                be_c    = off_c[1] ? 4'b1100 : 4'b0011;
                wlane_c = {2{cur_c.wdata[15:0]}};
            end
            default: be_c = '1;
        endcase

        rword_c = ram[idx_c];
        case (off_c[1:0])
            2'b00:   byte_c = rword_c[7:0];
            2'b01:   byte_c = rword_c[15:8];
            2'b10:   byte_c = rword_c[23:16];
            default: byte_c = rword_c[31:24];
        endcase
        half_c = off_c[1] ? rword_c[31:16] : rword_c[15:0];

        case (cur_c.f3)
            F3_B:    load_c = {{24{byte_c[7]}}, byte_c};
            F3_BU:   load_c = {24'h0, byte_c};
            F3_H:    load_c = {{16{half_c[15]}}, half_c};
            F3_HU:   load_c = {16'h0, half_c};
            F3_W:    load_c = rword_c;
            default: load_c = '0;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        commit_c    = 1'b0;
        ready_d     = 1'b0;
        busy_d      = busy;
        err_d       = 1'b0;
        read_data_d = read_data;

        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    req_d  = cur_c;
                    busy_d = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d  = S_RESP;
                        commit_c = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = S_RESP;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (commit_c) begin
            ready_d = 1'b1;
            err_d   = acc_err_c;
            if (acc_err_c) begin
                read_data_d = '0;
            end else if (cur_c.rd) begin
                read_data_d = load_c;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            read_data <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            read_data <= read_data_d;
            ready     <= ready_d;
            busy      <= busy_d;
            err       <= err_d;
        end
    end

    // RAM is never cleared; a store can only land outside reset.
    assign ram_we_c = commit_c && cur_c.wr && !acc_err_c && reset_n;

    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_c[i]) begin
                    ram[idx_c][8*i +: 8] <= wlane_c[8*i +: 8];
                end
            end
        end
    end

endmodule
